// File: rtl/vec_cache_write_arbiter_pkg.sv
// vec_cache_write_arbiter_pkg: shared vector cache op encodings, lane width and arbiter state type.
package vec_cache_write_arbiter_pkg;
  localparam int VEC_LANE_BITS = 32;
  typedef enum logic [1:0] {
    VEC_DATA_WRITE_DISABLE = 2'd0,
    VEC_DATA_WRITE_VEC     = 2'd1,
    VEC_DATA_WRITE_SCALAR  = 2'd2
  } VecDataWriteOp_t;
  typedef enum logic [1:0] {
    VEC_DATA_READ_DISABLE = 2'd0,
    VEC_DATA_READ_VEC     = 2'd1,
    VEC_DATA_READ_SCALAR  = 2'd2
  } VecDataReadOp_t;
  typedef enum logic {
    VEC_ARB_IDLE  = 1'b0,
    VEC_ARB_BURST = 1'b1
  } VecArbState_t;
  function automatic logic vec_write_op_ok(input VecDataWriteOp_t op);
    return op == VEC_DATA_WRITE_VEC || op == VEC_DATA_WRITE_SCALAR;
  endfunction
endpackage

// File: rtl/vec_cache_write_arbiter_rr_picker.sv
// vec_rr_picker: combinational first-valid-at-or-after-pointer picker with wrap.
module vec_rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);
  always_comb begin
    found = |valid;
    idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) if (valid[j]) idx = IW'(j);
    // a valid requester at or above the pointer overrides the wrapped one
    for (int j = NUM_REQ - 1; j >= 0; j--) if (valid[j] && j >= int'(ptr)) idx = IW'(j);
  end
endmodule

// File: rtl/vec_cache_write_arbiter.sv
// vec_cache_write_arbiter: round-robin burst arbiter for the vector cache write port, one register stage.
// Optional VEC_ARB_PRIO0_EN gives requester 0 strict priority whenever the arbiter is idle.
module vec_cache_write_arbiter
  import vec_cache_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int MAX_LEN = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int LW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1,
  localparam int PW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUM_REQ-1:0]                               req_valid,
  input  VecDataWriteOp_t [NUM_REQ-1:0]                    req_op,
  input  logic [NUM_REQ-1:0][AW-1:0]                       req_addr,
  input  logic [NUM_REQ-1:0][PW-1:0]                       req_param,
  input  logic [NUM_REQ-1:0][LW-1:0]                       req_len,
  input  logic [NUM_REQ-1:0][WIDTH-1:0][VEC_LANE_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]                               req_ready,
  output VecDataWriteOp_t                                  write_op,
  output logic [AW-1:0]                                    write_addr,
  output logic [PW-1:0]                                    write_param,
  output logic [WIDTH-1:0][VEC_LANE_BITS-1:0]              data_in,
  output logic [IW-1:0]                                    grant_id,
  output logic                                             busy
);
  VecArbState_t state_q, state_d;
  VecDataWriteOp_t write_op_q, write_op_d, op;
  logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d;
  logic [IW-1:0] pick_id, win_id, sel;
  logic [LW-1:0] beats_left_q, beats_left_d;
  logic [AW-1:0] next_addr_q, next_addr_d, write_addr_q, write_addr_d, addr;
  logic [PW-1:0] write_param_q, write_param_d;
  logic [WIDTH-1:0][VEC_LANE_BITS-1:0] data_in_q, data_in_d;
  logic pick_found, win_found, accept, adv;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [IW-1:0] req_inc(input logic [IW-1:0] r);
    return (r == IW'(NUM_REQ - 1)) ? '0 : r + 1'b1;
  endfunction

  vec_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_id)
  );

`ifdef VEC_ARB_PRIO0_EN
  assign win_found = req_valid[0] | pick_found;
  assign win_id    = req_valid[0] ? '0 : pick_id;
  assign adv       = sel != '0;
`else
  assign win_found = pick_found;
  assign win_id    = pick_id;
  assign adv       = 1'b1;
`endif

  assign sel    = (state_q == VEC_ARB_BURST) ? owner_q : win_id;
  assign accept = (state_q == VEC_ARB_BURST) ? req_valid[sel] : win_found;
  assign addr   = (state_q == VEC_ARB_BURST) ? next_addr_q : req_addr[sel];
  assign op     = req_op[sel];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beats_left_d = beats_left_q;
    next_addr_d = next_addr_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    write_op_d = VEC_DATA_WRITE_DISABLE;
    write_addr_d = write_addr_q;
    write_param_d = write_param_q;
    data_in_d = data_in_q;
    req_ready = '0;
    req_ready[sel] = accept;
    if (accept) begin
      grant_id_d = sel;
      next_addr_d = addr_inc(addr);
      // unsupported ops still consume their beat but leave the cache inputs untouched
      if (vec_write_op_ok(op)) begin
        write_op_d = op;
        write_addr_d = addr;
        write_param_d = req_param[sel];
        data_in_d = req_data[sel];
      end
      if (state_q == VEC_ARB_IDLE && req_len[sel] != '0) begin
        state_d = VEC_ARB_BURST;
        owner_d = sel;
        beats_left_d = req_len[sel];
      end else if (state_q == VEC_ARB_IDLE || beats_left_q == LW'(1)) begin
        state_d = VEC_ARB_IDLE;
        rr_ptr_d = adv ? req_inc(sel) : rr_ptr_q;
      end else begin
        beats_left_d = beats_left_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= VEC_ARB_IDLE;
      owner_q <= '0;
      beats_left_q <= '0;
      next_addr_q <= '0;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      write_op_q <= VEC_DATA_WRITE_DISABLE;
      write_addr_q <= '0;
      write_param_q <= '0;
      data_in_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beats_left_q <= beats_left_d;
      next_addr_q <= next_addr_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      write_op_q <= write_op_d;
      write_addr_q <= write_addr_d;
      write_param_q <= write_param_d;
      data_in_q <= data_in_d;
    end
  end

  assign write_op    = write_op_q;
  assign write_addr  = write_addr_q;
  assign write_param = write_param_q;
  assign data_in     = data_in_q;
  assign grant_id    = grant_id_q;
  assign busy        = state_q == VEC_ARB_BURST;
endmodule

// File: tb/tb_vec_cache_write_arbiter.sv
// tb_vec_cache_write_arbiter: directed bench for the write arbiter with a behavioural cache on its outputs.
module tb_vec_cache_write_arbiter;
  import vec_cache_write_arbiter_pkg::*;
  typedef logic [3:0][31:0] vec_t;
  localparam logic [31:0] F0 = 32'h00000000, F1 = 32'h3F800000, F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000, F4 = 32'h40800000, F5 = 32'h40A00000;
  localparam logic [31:0] F6 = 32'h40C00000, F7 = 32'h40E00000, F8 = 32'h41000000;
  localparam logic [31:0] F9 = 32'h41100000;

  logic clock = 1'b0;
  logic reset;
  logic [1:0] req_valid;
  VecDataWriteOp_t [1:0] req_op;
  logic [1:0][1:0] req_addr, req_param, req_len;
  logic [1:0][3:0][31:0] req_data;
  logic [1:0] req_ready;
  VecDataWriteOp_t write_op;
  logic [1:0] write_addr, write_param;
  logic [3:0][31:0] data_in;
  logic grant_id, busy;
  vec_t mem [4] = '{default: '0};
  int checks = 0;
  int errors = 0;

  vec_cache_write_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_param(req_param), .req_len(req_len), .req_data(req_data),
    .req_ready(req_ready), .write_op(write_op), .write_addr(write_addr),
    .write_param(write_param), .data_in(data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (write_op == VEC_DATA_WRITE_VEC) mem[write_addr] <= data_in;
    else if (write_op == VEC_DATA_WRITE_SCALAR) mem[write_addr][write_param] <= data_in[write_param];
  end

  function automatic vec_t v(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_op[0] = VEC_DATA_WRITE_DISABLE;
    req_op[1] = VEC_DATA_WRITE_DISABLE;
    req_addr = '0;
    req_param = '0;
    req_len = '0;
    req_data = '0;
    tick();
    chk("rst_op", write_op, VEC_DATA_WRITE_DISABLE);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", data_in, 0);
    chk("rst_ready", req_ready, 0);
    reset = 1'b0;

    // single VEC write
    req_valid = 2'b01; req_op[0] = VEC_DATA_WRITE_VEC; req_addr[0] = 2'd1;
    req_len[0] = 2'd0; req_data[0] = v(F9, F7, F5, F3);
    #1 chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("single_op", write_op, VEC_DATA_WRITE_VEC);
    chk("single_addr", write_addr, 1);
    chk("single_data", data_in, v(F9, F7, F5, F3));
    chk("single_busy", busy, 0);
    tick();
    chk("single_idle_op", write_op, VEC_DATA_WRITE_DISABLE);
    chk("single_hold_addr", write_addr, 1);
    chk("single_mem1", mem[1], v(F9, F7, F5, F3));

    // reset in the middle of a burst
    req_valid = 2'b01; req_addr[0] = 2'd2; req_len[0] = 2'd3; req_data[0] = v(F1, F2, F3, F4);
    #1 chk("rstb_ready", req_ready, 2'b01);
    tick();
    chk("rstb_addr0", write_addr, 2);
    chk("rstb_busy0", busy, 1);
    req_data[0] = v(F5, F6, F7, F8);
    tick();
    chk("rstb_addr1", write_addr, 3);
    #1 reset = 1'b1;
    #1;
    chk("rstb_op", write_op, VEC_DATA_WRITE_DISABLE);
    chk("rstb_addr", write_addr, 0);
    chk("rstb_data", data_in, 0);
    chk("rstb_busy", busy, 0);
    req_valid = 2'b00;
    tick();
    chk("rstb_mem2", mem[2], v(F1, F2, F3, F4));
    chk("rstb_mem3", mem[3], 0);
    reset = 1'b0;

`ifndef VEC_ARB_PRIO0_EN
    // contention: single-beat writes from both requesters
    req_op[1] = VEC_DATA_WRITE_VEC;
    req_addr[0] = 2'd0; req_len[0] = 2'd0; req_data[0] = v(F4, F6, F1, F6);
    req_addr[1] = 2'd2; req_len[1] = 2'd0; req_data[1] = v(F5, F3, F0, F3);
    req_valid = 2'b11;
    #1 chk("cont_ready0", req_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_op", write_op, VEC_DATA_WRITE_VEC);
      chk("cont_grant", grant_id, i % 2);
      chk("cont_addr", write_addr, (i % 2) ? 2 : 0);
      if (i < 3) chk("cont_ready", req_ready, (i % 2) ? 2'b01 : 2'b10);
    end
    req_valid = 2'b00;
    tick();
    chk("cont_idle_op", write_op, VEC_DATA_WRITE_DISABLE);
    chk("cont_mem0", mem[0], v(F4, F6, F1, F6));
    chk("cont_mem2", mem[2], v(F5, F3, F0, F3));

    // move the pointer to requester 1
    req_valid = 2'b01; req_addr[0] = 2'd1; req_data[0] = v(F9, F7, F5, F3);
    tick();
    req_valid = 2'b00;
    chk("pre_grant", grant_id, 0);

    // burst with address wrap, requester 0 locked out
    req_addr[1] = 2'd3; req_len[1] = 2'd2; req_data[1] = v(F1, F1, F1, F1);
    req_valid = 2'b11;
    #1 chk("burst_ready0", req_ready, 2'b10);
    tick();
    chk("burst_addr0", write_addr, 3);
    chk("burst_grant0", grant_id, 1);
    chk("burst_busy0", busy, 1);
    chk("burst_data0", data_in, v(F1, F1, F1, F1));
    req_data[1] = v(F2, F2, F2, F2);
    #1 chk("burst_ready1", req_ready, 2'b10);
    tick();
    chk("burst_addr1", write_addr, 0);
    chk("burst_op1", write_op, VEC_DATA_WRITE_VEC);
    chk("burst_busy1", busy, 1);
    req_data[1] = v(F3, F3, F3, F3);
    #1 chk("burst_ready2", req_ready, 2'b10);
    tick();
    chk("burst_addr2", write_addr, 1);
    chk("burst_data2", data_in, v(F3, F3, F3, F3));
    chk("burst_busy2", busy, 0);
    req_valid = 2'b01;
    #1 chk("burst_after_ready", req_ready, 2'b01);
    chk("burst_mem3", mem[3], v(F1, F1, F1, F1));
    chk("burst_mem0", mem[0], v(F2, F2, F2, F2));
    tick();
    chk("burst_after_grant", grant_id, 0);
    chk("burst_after_addr", write_addr, 1);
    req_valid = 2'b00;
    tick();
    chk("burst_mem1", mem[1], v(F9, F7, F5, F3));
`endif

    // scalar beat, two bubbles, then a vector beat
    req_op[0] = VEC_DATA_WRITE_SCALAR; req_addr[0] = 2'd1; req_param[0] = 2'd2;
    req_len[0] = 2'd1; req_data[0] = v(F8, F8, F2, F8); req_valid = 2'b01;
    #1 chk("scal_ready", req_ready, 2'b01);
    tick();
    chk("scal_op", write_op, VEC_DATA_WRITE_SCALAR);
    chk("scal_addr", write_addr, 1);
    chk("scal_param", write_param, 2);
    chk("scal_busy", busy, 1);
    req_valid = 2'b00;
    #1 chk("bub_ready", req_ready, 2'b00);
    tick();
    chk("bub1_op", write_op, VEC_DATA_WRITE_DISABLE);
    chk("bub1_busy", busy, 1);
    chk("bub1_addr", write_addr, 1);
    chk("scal_mem1", mem[1], v(F9, F7, F2, F3));
    tick();
    chk("bub2_op", write_op, VEC_DATA_WRITE_DISABLE);
    chk("bub2_busy", busy, 1);
    req_op[0] = VEC_DATA_WRITE_VEC; req_addr[0] = 2'd0; req_data[0] = v(F6, F6, F6, F6);
    req_valid = 2'b01;
    #1 chk("beat1_ready", req_ready, 2'b01);
    tick();
    chk("beat1_op", write_op, VEC_DATA_WRITE_VEC);
    chk("beat1_addr", write_addr, 2);
    chk("beat1_busy", busy, 0);
    req_valid = 2'b00;
    tick();
    chk("beat1_mem2", mem[2], v(F6, F6, F6, F6));

    // unsupported op is dropped but still granted
    req_op[1] = VecDataWriteOp_t'(2'd3); req_addr[1] = 2'd0; req_len[1] = 2'd0;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    chk("badop_op", write_op, VEC_DATA_WRITE_DISABLE);
    chk("badop_grant", grant_id, 1);
    chk("badop_hold_addr", write_addr, 2);

`ifdef VEC_ARB_PRIO0_EN
    // strict priority for requester 0
    req_op[0] = VEC_DATA_WRITE_VEC; req_op[1] = VEC_DATA_WRITE_VEC;
    req_addr[0] = 2'd0; req_len[0] = 2'd0; req_addr[1] = 2'd3; req_len[1] = 2'd0;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1 chk("prio_ready", req_ready, 2'b01);
      tick();
      chk("prio_grant", grant_id, 0);
    end
    req_valid = 2'b10;
    #1 chk("prio_ready1", req_ready, 2'b10);
    tick();
    chk("prio_grant1", grant_id, 1);
    chk("prio_addr1", write_addr, 3);
    req_valid = 2'b00;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
